// File: rtl/trig_divider_bank.sv
// Multi-channel trigger divider: one asynchronous trigger is synchronised,
// edge-detected, and fanned out to N_CH independent divide/phase/width lanes.
// Each lane holds a shadow configuration that is copied into the active set
// on a counter wrap, while disabled, or on a clear, so a ratio change never
// truncates a period.
module trig_divider_bank #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 32,
  parameter int PW_W  = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_trigger,
  input  logic [N_CH-1:0]         i_enable,
  input  logic [N_CH*CNT_W-1:0]   i_div,
  input  logic [N_CH*CNT_W-1:0]   i_phase,
  input  logic [N_CH*PW_W-1:0]    i_width,
  input  logic                    i_load,
  input  logic                    i_clr,
  output logic [N_CH-1:0]         o_pulse,
  output logic [N_CH-1:0]         o_wrap,
  output logic                    o_pending
);

  typedef struct packed {
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] ph;
    logic [PW_W-1:0]  w;
  } cfg_t;

  localparam cfg_t CFG_RST = '{div: '0, ph: '0, w: PW_W'(1)};

  // per-lane views of the flat configuration buses
  logic [N_CH-1:0][CNT_W-1:0] div_v;
  logic [N_CH-1:0][CNT_W-1:0] phase_v;
  logic [N_CH-1:0][PW_W-1:0]  width_v;
  logic [N_CH-1:0]            pend;

  assign div_v   = i_div;
  assign phase_v = i_phase;
  assign width_v = i_width;

  // sync[0]/sync[1] form the two-flop synchroniser, sync[2] is the edge flop
  logic [2:0] sync;
  logic       ev;

  // synchronise the trigger and register a one-cycle event per rising edge
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync <= '0;
      ev   <= 1'b0;
    end else begin
      sync <= {sync[1:0], i_trigger};
      ev   <= sync[1] & ~sync[2];
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    cfg_t             act;
    cfg_t             shd;
    logic [CNT_W-1:0] cnt;
    logic [PW_W-1:0]  pt;
    logic             hit;
    logic             fire;
    logic             wrp;
    logic             apply;
    logic [PW_W-1:0]  w_eff;

    // a clear in the same cycle discards the event entirely
    always_comb begin
      hit   = ev & i_enable[c] & ~i_clr;
      fire  = hit & (cnt == act.ph);
      wrp   = hit & (cnt == act.div);
      apply = wrp | ~i_enable[c] | i_clr;
      w_eff = (act.w == '0) ? PW_W'(1) : act.w;
    end

    // event counter; compare happens before increment so div=all-ones wraps cleanly
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        cnt <= '0;
      end else if (i_clr || !i_enable[c]) begin
        cnt <= '0;
      end else if (hit) begin
        cnt <= wrp ? '0 : cnt + CNT_W'(1);
      end
    end

    // shadow/active config; a load in an apply cycle leaves the new shadow pending
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        act     <= CFG_RST;
        shd     <= CFG_RST;
        pend[c] <= 1'b0;
      end else begin
        if (apply) begin
          act     <= shd;
          pend[c] <= 1'b0;
        end
        if (i_load) begin
          shd     <= '{div: div_v[c], ph: phase_v[c], w: width_v[c]};
          pend[c] <= 1'b1;
        end
      end
    end

    // pulse stretcher: pt counts the remaining high cycles including the current one,
    // so the output stays high while the pre-decrement value exceeds one
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        pt         <= '0;
        o_pulse[c] <= 1'b0;
        o_wrap[c]  <= 1'b0;
      end else begin
        if (fire) begin
          pt <= w_eff;
        end else if (pt != '0) begin
          pt <= pt - PW_W'(1);
        end
        o_pulse[c] <= fire | (pt > PW_W'(1));
        o_wrap[c]  <= wrp;
      end
    end
  end

  assign o_pending = |pend;

endmodule

// File: tb/tb_trig_divider_bank.sv
// Scoreboard bench for trig_divider_bank: an event-level model predicts fire,
// wrap and pulse width per trigger; the monitor compares every cycle.
module tb_trig_divider_bank;
  localparam int N_CH  = 4;
  localparam int CNT_W = 32;
  localparam int PW_W  = 8;

  logic                  clk = 1'b0;
  logic                  i_rst;
  logic                  i_trigger;
  logic [N_CH-1:0]       i_enable;
  logic [N_CH*CNT_W-1:0] i_div;
  logic [N_CH*CNT_W-1:0] i_phase;
  logic [N_CH*PW_W-1:0]  i_width;
  logic                  i_load;
  logic                  i_clr;
  logic [N_CH-1:0]       o_pulse;
  logic [N_CH-1:0]       o_wrap;
  logic                  o_pending;

  trig_divider_bank #(.N_CH(N_CH), .CNT_W(CNT_W), .PW_W(PW_W)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_trigger(i_trigger), .i_enable(i_enable),
    .i_div(i_div), .i_phase(i_phase), .i_width(i_width), .i_load(i_load),
    .i_clr(i_clr), .o_pulse(o_pulse), .o_wrap(o_wrap), .o_pending(o_pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int                   due;
    logic [N_CH-1:0]      fire;
    logic [N_CH-1:0]      wrap;
    logic [N_CH-1:0][8:0] weff;
  } rec_t;

  rec_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   mon_on = 1'b0;
  int   hi_until[N_CH];

  logic [31:0] m_cnt[N_CH];
  logic [31:0] act_d[N_CH], act_p[N_CH], shd_d[N_CH], shd_p[N_CH];
  logic [7:0]  act_w[N_CH], shd_w[N_CH];
  bit          m_en[N_CH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void m_apply(input int c);
    act_d[c] = shd_d[c];
    act_p[c] = shd_p[c];
    act_w[c] = shd_w[c];
  endfunction

  function automatic void m_reset();
    for (int c = 0; c < N_CH; c++) begin
      act_d[c] = 0; act_p[c] = 0; act_w[c] = 1;
      shd_d[c] = 0; shd_p[c] = 0; shd_w[c] = 1;
      m_cnt[c] = 0;
      m_en[c]  = i_enable[c];
    end
  endfunction

  // per-cycle monitor: pops the expected event record when it falls due
  always @(negedge clk) begin : mon
    rec_t            r;
    logic [N_CH-1:0] ew, ep;
    if (i_rst) begin
      for (int c = 0; c < N_CH; c++) hi_until[c] = -1;
    end else if (mon_on) begin
      ew = '0;
      if (sb.size() > 0 && sb[0].due < cyc) begin
        chk("sb_late", sb[0].due, cyc);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        r  = sb.pop_front();
        ew = r.wrap;
        for (int c = 0; c < N_CH; c++)
          if (r.fire[c]) hi_until[c] = cyc + int'(r.weff[c]) - 1;
      end
      for (int c = 0; c < N_CH; c++) ep[c] = (cyc <= hi_until[c]);
      chk("wrap", 32'(o_wrap), 32'(ew));
      chk("pulse", 32'(o_pulse), 32'(ep));
    end
  end

  task automatic set_cfg(input int c, input logic [31:0] d, input logic [31:0] p, input logic [7:0] w);
    i_div[c*CNT_W +: CNT_W]  = d;
    i_phase[c*CNT_W +: CNT_W] = p;
    i_width[c*PW_W +: PW_W]  = w;
  endtask

  task automatic set_en(input logic [N_CH-1:0] e);
    i_enable = e;
    for (int c = 0; c < N_CH; c++) begin
      m_en[c] = e[c];
      if (!e[c]) begin m_cnt[c] = 0; m_apply(c); end
    end
    @(negedge clk);
  endtask

  task automatic do_load();
    i_load = 1'b1;
    for (int c = 0; c < N_CH; c++) begin
      shd_d[c] = i_div[c*CNT_W +: CNT_W];
      shd_p[c] = i_phase[c*CNT_W +: CNT_W];
      shd_w[c] = i_width[c*PW_W +: PW_W];
    end
    @(negedge clk);
    i_load = 1'b0;
    for (int c = 0; c < N_CH; c++) if (!m_en[c]) m_apply(c);
    @(negedge clk);
  endtask

  task automatic program_all(input logic [31:0] d, input logic [31:0] p, input logic [7:0] w);
    for (int c = 0; c < N_CH; c++) set_cfg(c, d, p, w);
    set_en('0);
    do_load();
    set_en('1);
  endtask

  // one trigger event every 4 cycles; outputs fall due 4 negedges after the raise
  task automatic fire_trig(input bit with_clr);
    rec_t r;
    r = '0;
    r.due = cyc + 4;
    for (int c = 0; c < N_CH; c++) begin
      if (with_clr) begin
        m_cnt[c] = 0;
        m_apply(c);
      end else if (m_en[c]) begin
        r.fire[c] = (m_cnt[c] == act_p[c]);
        r.wrap[c] = (m_cnt[c] == act_d[c]);
        r.weff[c] = (act_w[c] == 0) ? 9'd1 : {1'b0, act_w[c]};
        m_cnt[c]  = r.wrap[c] ? 0 : m_cnt[c] + 1;
        if (r.wrap[c]) m_apply(c);
      end
    end
    sb.push_back(r);
    i_trigger = 1'b1;
    @(negedge clk);
    @(negedge clk);
    i_trigger = 1'b0;
    @(negedge clk);
    if (with_clr) i_clr = 1'b1;
    @(negedge clk);
    i_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : wdog
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, prev;
    i_rst = 1'b1; i_trigger = 1'b0; i_enable = '1;
    i_div = '0; i_phase = '0; i_width = '0; i_load = 1'b0; i_clr = 1'b0;
    for (int c = 0; c < N_CH; c++) set_cfg(c, 0, 0, 1);
    idle(3);
    chk("rst_pulse", 32'(o_pulse), 0);
    chk("rst_wrap", 32'(o_wrap), 0);
    chk("rst_pend", 32'(o_pending), 0);
    @(posedge clk); #2 i_rst = 1'b0;
    m_reset(); sb.delete(); mon_on = 1'b1;
    @(negedge clk);

    // asynchronous reset during a long pulse with a pending shadow
    program_all(0, 0, 20);
    fire_trig(0);
    do_load();
    chk("pre_rst_pulse", 32'(o_pulse), 32'hF);
    chk("pre_rst_pend", 32'(o_pending), 1);
    mon_on = 1'b0;
    @(posedge clk); #2 i_rst = 1'b1;
    #1;
    chk("arst_pulse", 32'(o_pulse), 0);
    chk("arst_wrap", 32'(o_wrap), 0);
    chk("arst_pend", 32'(o_pending), 0);
    idle(2);
    @(posedge clk); #2 i_rst = 1'b0;
    for (int c = 0; c < N_CH; c++) set_cfg(c, 0, 0, 1);
    m_reset(); sb.delete(); mon_on = 1'b1;
    @(negedge clk);
    repeat (10) fire_trig(0);
    idle(3);

    // divide and phase
    set_cfg(0, 3, 0, 2); set_cfg(1, 3, 2, 2); set_cfg(2, 4, 4, 2); set_cfg(3, 1, 1, 3);
    set_en('0); do_load(); set_en('1);
    repeat (20) fire_trig(0);
    idle(4);

    // hot reload: D=7 running, reload to D=2 after event 3
    program_all(7, 0, 1);
    repeat (3) fire_trig(0);
    for (int c = 0; c < N_CH; c++) set_cfg(c, 2, 0, 1);
    do_load();
    chk("pend_set", 32'(o_pending), 1);
    repeat (4) fire_trig(0);
    chk("pend_hold", 32'(o_pending), 1);
    fire_trig(0);
    chk("pend_clr", 32'(o_pending), 0);
    repeat (7) fire_trig(0);
    idle(3);

    // stretch / retrigger, then zero width
    program_all(0, 0, 10);
    repeat (5) fire_trig(0);
    idle(14);
    program_all(0, 0, 0);
    repeat (3) fire_trig(0);
    idle(3);

    // phase beyond divide never fires
    set_cfg(0, 3, 5, 1);
    for (int c = 1; c < N_CH; c++) set_cfg(c, 3, 0, 1);
    set_en('0); do_load(); set_en('1);
    repeat (8) fire_trig(0);

    // clear coincident with an event, then a disabled stretch
    program_all(3, 0, 1);
    repeat (2) fire_trig(0);
    fire_trig(1);
    fire_trig(0);
    set_en(4'b1101);
    repeat (3) fire_trig(0);
    set_en('1);
    repeat (2) fire_trig(0);
    idle(3);

    // short glitches at random clock phase: never more than one pulse each
    program_all(0, 0, 1);
    mon_on = 1'b0;
    repeat (8) begin
      @(negedge clk);
      #($urandom_range(0, 9)) i_trigger = 1'b1;
      #($urandom_range(1, 9)) i_trigger = 1'b0;
      n = 0; prev = 0;
      repeat (8) begin
        @(negedge clk);
        if (o_pulse[0] && prev == 0) n++;
        prev = int'(o_pulse[0]);
      end
      chk("glitch_le1", 32'(n <= 1), 1);
    end

    chk("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
